uart_rx_mmio: RTL

- UART receiver peripheral for the uart_rx pin; the receive-side counterpart of the existing transmit-only UART.
- Deserialises 8N1 frames into a byte FIFO and exposes DATA/STATUS registers on the shared MMIO data bus.
- Answers with a one-cycle mmio_done pulse, ORed into the Memory done path alongside the LED, UART-TX and LCD peripherals.

---
 rtl/uart_rx_mmio_if.sv | 20 ++
 rtl/uart_rx_mmio.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mmio_if.sv
// MMIO bus bundle shared by the memory-mapped peripherals: one request level from the
// initiator, one done pulse plus read data back from the addressed peripheral.
interface uart_rx_mmio_if;
  logic [15:0] mmio_addr;
  logic [7:0]  mmio_data;
  logic        mmio_write;
  logic        mmio_req;
  logic        mmio_done;
  logic [7:0]  mmio_rdata;

  modport master (
    output mmio_addr, mmio_data, mmio_write, mmio_req,
    input  mmio_done, mmio_rdata
  );

  modport slave (
    input  mmio_addr, mmio_data, mmio_write, mmio_req,
    output mmio_done, mmio_rdata
  );
endinterface

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver feeding a byte FIFO, read through DATA/STATUS registers on the MMIO bus.
// STATUS = {4'b0, ferr, ovr, full, not_empty}; ovr/ferr are sticky and write-1-to-clear.
module uart_rx_mmio #(
  parameter int unsigned CLOCK_FREQ  = 27000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] ADDR_DATA   = 16'hFF10,
  parameter logic [15:0] ADDR_STATUS = 16'hFF11
) (
  input  logic           clock,
  input  logic           reset,
  uart_rx_mmio_if.slave  mmio,
  input  logic           rx,
  output logic           rx_irq
);

  localparam int unsigned ClksPerBit = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] BitLast   = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfLast  = CntW'(ClksPerBit / 2 - 1);
  localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {BusIdle, BusAccept, BusWaitLow} bus_state_e;

  rx_state_e         rx_state_q, rx_state_d;
  bus_state_e        bus_state_q, bus_state_d;
  logic [1:0]        sync_q;
  logic              rx_s;
  logic [CntW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              armed_q, armed_d;
  logic              rx_push, ferr_set;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q, count_d;
  logic              fifo_empty, fifo_full, push_ok, pop_ok, pop_req, ovr_set;
  logic              ovr_q, ovr_d, ferr_q, ferr_d, irq_q;

  logic              addr_hit, is_data, accept, clr_ovr, clr_ferr;
  logic [7:0]        status, rdata_q, rdata_d;

  assign rx_s = sync_q[1];

  // After a bad stop bit the line may still be low; armed_q blocks a retrigger until it idles.
  always_comb begin
    rx_state_d = rx_state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          bit_cnt_d  = '0;
          clk_cnt_d  = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (clk_cnt_q == HalfLast) begin
          clk_cnt_d  = '0;
          rx_state_d = rx_s ? RxIdle : RxData;
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RxStop;
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d  = '0;
          rx_state_d = RxIdle;
          if (rx_s) begin
            rx_push = 1'b1;
          end else begin
            ferr_set = 1'b1;
            armed_d  = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CountFull);
  assign push_ok    = rx_push & ~fifo_full;
  assign ovr_set    = rx_push & fifo_full;
  assign pop_ok     = pop_req & ~fifo_empty;
  assign status     = {4'b0000, ferr_q, ovr_q, fifo_full, ~fifo_empty};

  assign addr_hit = (mmio.mmio_addr == ADDR_DATA) || (mmio.mmio_addr == ADDR_STATUS);
  assign is_data  = (mmio.mmio_addr == ADDR_DATA);
  assign accept   = (bus_state_q == BusIdle) && mmio.mmio_req && addr_hit;
  assign pop_req  = accept & ~mmio.mmio_write & is_data;
  assign clr_ovr  = accept & mmio.mmio_write & ~is_data & ((mmio.mmio_data & 8'h04) != 8'h00);
  assign clr_ferr = accept & mmio.mmio_write & ~is_data & ((mmio.mmio_data & 8'h08) != 8'h00);

  // Set wins over a simultaneous clear.
  assign ovr_d  = ovr_set | (ovr_q & ~clr_ovr);
  assign ferr_d = ferr_set | (ferr_q & ~clr_ferr);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + (PtrW + 1)'(1);
    if (!push_ok && pop_ok) count_d = count_q - (PtrW + 1)'(1);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (accept && !mmio.mmio_write) begin
      if (is_data) rdata_d = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
      else         rdata_d = status;
    end
  end

  always_comb begin
    bus_state_d = bus_state_q;
    unique case (bus_state_q)
      BusIdle:    if (accept) bus_state_d = BusAccept;
      BusAccept:  bus_state_d = BusWaitLow;
      BusWaitLow: if (!mmio.mmio_req) bus_state_d = BusIdle;
      default:    bus_state_d = BusIdle;
    endcase
  end

  assign mmio.mmio_done  = (bus_state_q == BusAccept);
  assign mmio.mmio_rdata = rdata_q;
  assign rx_irq          = irq_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q      <= 2'b11;
      rx_state_q  <= RxIdle;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
      bus_state_q <= BusIdle;
    end else begin
      sync_q      <= {sync_q[0], rx};
      rx_state_q  <= rx_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q     <= count_d;
      ovr_q       <= ovr_d;
      ferr_q      <= ferr_d;
      irq_q       <= ~fifo_empty;
      rdata_q     <= rdata_d;
      bus_state_q <= bus_state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= shift_q;
  end

endmodule
